alu_result_fifo: RTL and testbench

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

---
 rtl/alu_pkg.sv | 20 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/alu_result_fifo.sv | 84 ++++++++
 tb/tb_alu_result_fifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU result FIFO: storage geometry and the
// active-low seven-segment patterns used by the display decoders.
package alu_pkg;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed table indexed by hex digit: element 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7Of(input logic [3:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Purely combinational hex digit to active-low seven-segment decoder.
import alu_pkg::*;

module seg7_decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7Of(digit_i);

endmodule

// File: rtl/alu_result_fifo.sv
// Four-entry FIFO of ALU results driven by edge-detected push/pop keys,
// showing the head entry and the occupancy on three seven-segment digits.
import alu_pkg::*;

module alu_result_fifo #(
  parameter int DEPTH = alu_pkg::DEPTH
) (
  input  logic       Clock,
  input  logic       Reset_b,
  input  logic [7:0] ALUout,
  input  logic       Push,
  input  logic       Pop,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       Full,
  output logic       Empty,
  output logic       Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_q, pop_q, overflow_q, overflow_d;
  logic              pushEv, popEv, pushAcc, popAcc;
  logic [6:0]        headLoSeg, headHiSeg, countSeg;
  logic [DATA_W-1:0] head;

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a push that coincides with a pop.
  always_comb begin
    pushEv     = Push & ~push_q;
    popEv      = Pop & ~pop_q;
    Full       = (count_q == CNT_W'(DEPTH));
    Empty      = (count_q == '0);
    popAcc     = popEv & ~Empty;
    pushAcc    = pushEv & (~Full | popAcc);
    wrPtr_d    = pushAcc ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d    = popAcc ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d    = count_q;
    if (pushAcc && !popAcc) count_d = count_q + 1'b1;
    if (popAcc && !pushAcc) count_d = count_q - 1'b1;
    overflow_d = overflow_q | (pushEv & Full & ~popAcc);
  end

  // Edge history resets high so a key already held at reset release must be
  // released and pressed again before it counts.
  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      push_q     <= 1'b1;
      pop_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      push_q     <= Push;
      pop_q      <= Pop;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (pushAcc) mem_q[wrPtr_q] <= ALUout;
  end

  assign head     = mem_q[rdPtr_q];
  assign Overflow = overflow_q;

  seg7_decoder uHex0 (.digit_i(head[3:0]), .seg_o(headLoSeg));
  seg7_decoder uHex1 (.digit_i(head[7:4]), .seg_o(headHiSeg));
  seg7_decoder uHex2 (.digit_i({1'b0, count_q}), .seg_o(countSeg));

  assign HEX0 = Empty ? SEG_BLANK : headLoSeg;
  assign HEX1 = Empty ? SEG_BLANK : headHiSeg;
  assign HEX2 = countSeg;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed test of the ALU result FIFO against hand-computed display values.
module tb_alu_result_fifo;

  logic       Clock = 1'b0;
  logic       Reset_b;
  logic [7:0] ALUout;
  logic       Push, Pop;
  logic [6:0] HEX0, HEX1, HEX2;
  logic       Full, Empty, Overflow;

  int testsRun    = 0;
  int testsFailed = 0;

  alu_result_fifo dut (
    .Clock(Clock), .Reset_b(Reset_b), .ALUout(ALUout), .Push(Push), .Pop(Pop),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .Full(Full), .Empty(Empty), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  // One press: raise the requested keys for one cycle, then release them.
  task automatic applyStimulus(input logic doPush, input logic doPop, input logic [7:0] data);
    @(negedge Clock);
    ALUout = data;
    Push   = doPush;
    Pop    = doPop;
    @(negedge Clock);
    Push   = 1'b0;
    Pop    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset_b = 1'b1;
    Push    = 1'b0;
    Pop     = 1'b0;
    ALUout  = 8'h00;
    #2 Reset_b = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("rst_empty", {7'b0, Empty}, 8'h01);
    checkOutput("rst_full", {7'b0, Full}, 8'h00);
    checkOutput("rst_ovf", {7'b0, Overflow}, 8'h00);
    checkOutput("rst_hex2", {1'b0, HEX2}, 8'h40);
    checkOutput("rst_hex1", {1'b0, HEX1}, 8'h7F);
    checkOutput("rst_hex0", {1'b0, HEX0}, 8'h7F);
    Reset_b = 1'b1;
    @(negedge Clock);

    applyStimulus(1'b1, 1'b0, 8'h3C);
    checkOutput("push3c_hex1", {1'b0, HEX1}, 8'h30);
    checkOutput("push3c_hex0", {1'b0, HEX0}, 8'h46);
    checkOutput("push3c_hex2", {1'b0, HEX2}, 8'h79);
    checkOutput("push3c_empty", {7'b0, Empty}, 8'h00);

    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop3c_empty", {7'b0, Empty}, 8'h01);
    checkOutput("pop3c_hex0", {1'b0, HEX0}, 8'h7F);
    checkOutput("pop3c_hex2", {1'b0, HEX2}, 8'h40);

    applyStimulus(1'b1, 1'b0, 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h02);
    applyStimulus(1'b1, 1'b0, 8'h03);
    applyStimulus(1'b1, 1'b0, 8'h04);
    checkOutput("fill_full", {7'b0, Full}, 8'h01);
    checkOutput("fill_hex2", {1'b0, HEX2}, 8'h19);
    checkOutput("fill_hex1", {1'b0, HEX1}, 8'h40);
    checkOutput("fill_hex0", {1'b0, HEX0}, 8'h79);

    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("ovf_flag", {7'b0, Overflow}, 8'h01);
    checkOutput("ovf_full", {7'b0, Full}, 8'h01);
    checkOutput("ovf_hex2", {1'b0, HEX2}, 8'h19);
    checkOutput("ovf_hex0", {1'b0, HEX0}, 8'h79);

    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop1_hex0", {1'b0, HEX0}, 8'h24);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop2_hex0", {1'b0, HEX0}, 8'h30);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop3_hex0", {1'b0, HEX0}, 8'h19);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop4_empty", {7'b0, Empty}, 8'h01);
    checkOutput("pop4_hex1", {1'b0, HEX1}, 8'h7F);
    checkOutput("pop4_hex0", {1'b0, HEX0}, 8'h7F);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("pop6_empty", {7'b0, Empty}, 8'h01);
    checkOutput("pop6_hex2", {1'b0, HEX2}, 8'h40);
    checkOutput("pop6_ovf_sticky", {7'b0, Overflow}, 8'h01);

    @(negedge Clock);
    ALUout = 8'hA5;
    Push   = 1'b1;
    repeat (10) @(negedge Clock);
    Push   = 1'b0;
    @(negedge Clock);
    checkOutput("hold_hex2", {1'b0, HEX2}, 8'h79);
    checkOutput("hold_hex1", {1'b0, HEX1}, 8'h08);
    checkOutput("hold_hex0", {1'b0, HEX0}, 8'h12);

    applyStimulus(1'b1, 1'b0, 8'h7E);
    checkOutput("two_hex2", {1'b0, HEX2}, 8'h24);
    applyStimulus(1'b1, 1'b1, 8'h5B);
    checkOutput("both2_hex2", {1'b0, HEX2}, 8'h24);
    checkOutput("both2_hex1", {1'b0, HEX1}, 8'h78);
    checkOutput("both2_hex0", {1'b0, HEX0}, 8'h06);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("tail_hex1", {1'b0, HEX1}, 8'h12);
    checkOutput("tail_hex0", {1'b0, HEX0}, 8'h03);
    checkOutput("tail_hex2", {1'b0, HEX2}, 8'h79);

    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h66);
    checkOutput("both0_hex2", {1'b0, HEX2}, 8'h79);
    checkOutput("both0_hex1", {1'b0, HEX1}, 8'h02);
    checkOutput("both0_hex0", {1'b0, HEX0}, 8'h02);

    @(negedge Clock);
    #2 Reset_b = 1'b0;
    #1;
    checkOutput("async_empty", {7'b0, Empty}, 8'h01);
    checkOutput("async_ovf", {7'b0, Overflow}, 8'h00);
    checkOutput("async_hex2", {1'b0, HEX2}, 8'h40);
    checkOutput("async_hex0", {1'b0, HEX0}, 8'h7F);
    ALUout = 8'h12;
    Push   = 1'b1;
    @(negedge Clock);
    Reset_b = 1'b1;
    repeat (2) @(negedge Clock);
    checkOutput("held_push_empty", {7'b0, Empty}, 8'h01);
    Push = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h12);
    checkOutput("repress_hex2", {1'b0, HEX2}, 8'h79);
    checkOutput("repress_hex0", {1'b0, HEX0}, 8'h24);

    applyStimulus(1'b1, 1'b0, 8'h22);
    applyStimulus(1'b1, 1'b0, 8'h33);
    applyStimulus(1'b1, 1'b0, 8'h44);
    applyStimulus(1'b1, 1'b1, 8'h99);
    checkOutput("both4_full", {7'b0, Full}, 8'h01);
    checkOutput("both4_hex2", {1'b0, HEX2}, 8'h19);
    checkOutput("both4_hex1", {1'b0, HEX1}, 8'h24);
    checkOutput("both4_ovf", {7'b0, Overflow}, 8'h00);
    repeat (3) applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("both4_tail_hex1", {1'b0, HEX1}, 8'h10);
    checkOutput("both4_tail_hex0", {1'b0, HEX0}, 8'h10);
    checkOutput("both4_tail_hex2", {1'b0, HEX2}, 8'h79);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
